// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the HH:MM:SS time-setting controller.
//   edit_state_t : edit FSM states (RUN, SET_H, SET_M, SET_S)
//   *_W / *_MAX  : field widths and wrap limits for hour, minute, second
//   *_MASK       : blink_mask bits belonging to each field {h2,h1,m2,m1,s2,s1}
//   cnt_width()  : ceil(log2(n)) with a floor of one bit
// -----------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } edit_state_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

   localparam logic [5:0] HOUR_MASK = 6'b110000;
   localparam logic [5:0] MIN_MASK  = 6'b001100;
   localparam logic [5:0] SEC_MASK  = 6'b000011;

   // A counter that must hold 0..n-1 needs ceil(log2(n)) bits; a one-state
   // counter still gets a single bit so it can be declared.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_counter_wrap.sv
// -----------------------------------------------------------------------------
// mod_counter_wrap
// Shadow field register: parallel load, +1 with wrap from MAX to 0.
//   clk      in  1  system clock
//   reset    in  1  synchronous, active-high reset (value -> 0)
//   inc      in  1  add one, wrapping MAX -> 0
//   load     in  1  take load_val (has priority over inc)
//   load_val in  W  value to load
//   value    out W  current field value
// -----------------------------------------------------------------------------
module mod_counter_wrap #(
   parameter int         W   = 6,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value
);

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= (value >= MAX) ? '0 : value + 1'b1;
   end

endmodule

// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
// Freezes the time counter, lets the user edit hours, minutes and seconds in
// turn, blinks the field being edited and commits with a one-cycle load.
//   clk         in  1  system clock
//   reset       in  1  synchronous, active-high reset
//   mode_pulse  in  1  advance edit field (RUN->H->M->S->RUN)
//   inc_pulse   in  1  increment selected field
//   inc_level   in  1  increment button level, drives auto-repeat
//   cur_hour    in  5  live hour from the counter
//   cur_min     in  6  live minute
//   cur_sec     in  6  live second
//   run_en      out 1  counter enable, 0 while editing
//   load        out 1  one-cycle commit strobe
//   load_hour   out 5  shadow hour
//   load_min    out 6  shadow minute
//   load_sec    out 6  shadow second
//   blink_mask  out 6  per-digit blank request {h2,h1,m2,m1,s2,s1}
//   edit_state  out 2  current FSM state
// -----------------------------------------------------------------------------
module time_set_controller
   import clock_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BLINK_HALF_CYC = 12_500_000,
   parameter int REPEAT_CYC     = 12_500_000,
   parameter int TIMEOUT_SEC    = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode_pulse,
   input  logic              inc_pulse,
   input  logic              inc_level,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   output logic              run_en,
   output logic              load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MIN_W-1:0]  load_min,
   output logic [SEC_W-1:0]  load_sec,
   output logic [5:0]        blink_mask,
   output logic [1:0]        edit_state
);

   localparam int BLINK_W = cnt_width(BLINK_HALF_CYC);
   localparam int REP_W   = cnt_width(REPEAT_CYC);
   localparam int PRE_W   = cnt_width(CLK_HZ);
   localparam int TOUT_W  = cnt_width(TIMEOUT_SEC);

   // Terminal counts; each value is below 2**width so the sizing is exact.
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);
   localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_CYC - 1);
   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_HZ - 1);
   localparam logic [TOUT_W-1:0]  TOUT_LAST  = TOUT_W'(TIMEOUT_SEC - 1);

   edit_state_t        state, state_nxt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic [REP_W-1:0]   rep_cnt;
   logic [PRE_W-1:0]   pre_cnt;
   logic [TOUT_W-1:0]  tout_cnt;

   logic in_set, capture, rep_fire, inc_req, activity, sec_tick, timeout;

   assign in_set   = (state != RUN);
   assign capture  = (state == RUN) && mode_pulse;
   // A pulse restarts the repeat interval, so it never doubles up with a repeat.
   assign rep_fire = in_set && inc_level && !inc_pulse && (rep_cnt == REP_LAST);
   // Mode wins over a same-cycle increment.
   assign inc_req  = in_set && !mode_pulse && (inc_pulse || rep_fire);
   assign activity = mode_pulse || inc_req;
   assign sec_tick = (pre_cnt == PRE_LAST);
   assign timeout  = in_set && !activity && sec_tick && (tout_cnt == TOUT_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch
      // is inferred for signals a branch happens not to mention.
      state_nxt = state;
      if (mode_pulse) begin
         case (state)
            RUN:   state_nxt = SET_H;
            SET_H: state_nxt = SET_M;
            SET_M: state_nxt = SET_S;
            SET_S: state_nxt = RUN;
         endcase
      end else if (timeout) begin
         state_nxt = RUN;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      run_en     = (state == RUN);
      edit_state = state;
      blink_mask = '0;
      if (blink_phase) begin
         case (state)
            SET_H:   blink_mask = HOUR_MASK;
            SET_M:   blink_mask = MIN_MASK;
            SET_S:   blink_mask = SEC_MASK;
            default: blink_mask = '0;
         endcase
      end
   end

   // Commit strobe is registered so it lines up with the return to RUN.
   always_ff @(posedge clk) begin
      if (reset)
         load <= 1'b0;
      else
         load <= (state == SET_S) && mode_pulse;
   end

   // ---------------- auto-repeat ----------------
   always_ff @(posedge clk) begin
      if (reset || inc_pulse || !inc_level || !in_set)
         rep_cnt <= '0;
      else if (rep_cnt == REP_LAST)
         rep_cnt <= '0;
      else
         rep_cnt <= rep_cnt + 1'b1;
   end

   // ---------------- blink ----------------
   // Activity restarts the visible half so the field shows right after a press.
   always_ff @(posedge clk) begin
      if (reset || activity) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // ---------------- edit timeout ----------------
   always_ff @(posedge clk) begin
      if (reset || activity || !in_set) begin
         pre_cnt  <= '0;
         tout_cnt <= '0;
      end else if (sec_tick) begin
         pre_cnt  <= '0;
         tout_cnt <= (tout_cnt == TOUT_LAST) ? '0 : tout_cnt + 1'b1;
      end else begin
         pre_cnt  <= pre_cnt + 1'b1;
      end
   end

   // ---------------- shadow fields ----------------
   mod_counter_wrap #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_req && (state == SET_H)),
      .load     (capture),
      .load_val (cur_hour),
      .value    (load_hour)
   );

   mod_counter_wrap #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_req && (state == SET_M)),
      .load     (capture),
      .load_val (cur_min),
      .value    (load_min)
   );

   mod_counter_wrap #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc_req && (state == SET_S)),
      .load     (capture),
      .load_val (cur_sec),
      .value    (load_sec)
   );

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Mode/sequencing controller for the HH:MM:SS timekeeping datapath.
- Freezes the time counter, lets the user edit hours, minutes and seconds in turn with debounced pushbutton pulses, and shows which field is being edited by blinking it.
- Commits the edited time back to the counter with a single-cycle parallel load.
- Sits between the debounce/edge-detect stage and the counter/display datapath; the counter gains run_en and load inputs.

Parameters:
- CLK_HZ, 50_000_000: clock frequency; sets the one-second tick for the timeout.
- BLINK_HALF_CYC, 12_500_000: cycles per blink half-period (2 Hz blink).
- REPEAT_CYC, 12_500_000: auto-repeat interval while the increment button is held.
- TIMEOUT_SEC, 10: seconds without a button pulse before an edit is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode_pulse  in  1  one-cycle debounced pulse; advances the edit field
- inc_pulse  in  1  one-cycle debounced pulse; increments the selected field
- inc_level  in  1  debounced level of the increment button, used for auto-repeat
- cur_hour  in  5  live hour from the counter (0-23)
- cur_min  in  6  live minute (0-59)
- cur_sec  in  6  live second (0-59)
- run_en  out  1  counter enable; 0 while editing
- load  out  1  one-cycle strobe; counter takes load_hour/min/sec
- load_hour  out  5  shadow hour
- load_min  out  6  shadow minute
- load_sec  out  6  shadow second
- blink_mask  out  6  per-digit blank request; 1 = blank. Bit order {h2,h1,m2,m1,s2,s1} = bits [5:0]
- edit_state  out  2  current state encoding, for debug and LEDs

Behaviour:
- Reset: clock and reset are as stated above (synchronous, active-high). Reset values: state RUN, run_en=1, load=0, blink_mask=0, shadow registers=0, blink/repeat/timeout counters=0. Asserting reset mid-edit abandons the edit with no load.
- States:
  - RUN=0: run_en=1, mask=0.
  - SET_H=1, SET_M=2, SET_S=3: run_en=0.
- Transitions on mode_pulse:
  - RUN->SET_H: captures cur_* into the shadow registers in the same cycle.
  - SET_H->SET_M, SET_M->SET_S.
  - SET_S->RUN: load=1 for exactly that one cycle, from registered outputs. run_en returns to 1 in the same cycle as load. The counter must prioritise load over run_en and must reset its sub-second prescaler on load.
- inc_pulse in RUN: ignored.
- inc_pulse in SET_x: selected shadow field +1 next cycle, with wrap-around: hour 23->0, min 59->0, sec 59->0. No carry between fields.
- Same-cycle mode_pulse and inc_pulse: mode wins; the increment is dropped.
- Auto-repeat:
  - The repeat counter clears on inc_pulse and whenever inc_level=0.
  - While inc_level=1 in SET_x, the counter runs. Each time it reaches REPEAT_CYC-1 it generates one increment and wraps to 0.
  - The first auto-increment therefore comes REPEAT_CYC cycles after the pulse.
- Blink:
  - A free-running counter toggles blink_phase every BLINK_HALF_CYC cycles.
  - Any increment (pulse or repeat) or mode_pulse clears the counter and the phase, so the field is visible right after activity.
  - blink_mask = two bits of the selected field when in SET_x and blink_phase=1, else 0.
  - Field bits: hours = [5:4], minutes = [3:2], seconds = [1:0].
- Timeout:
  - Cycle prescaler to a 1 s tick; the seconds counter counts ticks in SET_x.
  - Prescaler and seconds counter both clear on any mode_pulse or increment.
  - At TIMEOUT_SEC ticks: return to RUN with no load. The counter resumes from its frozen value.
- load_* outputs always present the shadow registers. They are meaningful only while load=1.
- Counter widths: ceil(log2) of each parameter. Comparisons are done at full width; no truncation.

Decomposition:
- Package clock_pkg:
  - typedef enum logic[1:0] edit_state_t {RUN, SET_H, SET_M, SET_S}.
  - Constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Field mask constants.
- One natural sub-module, mod_counter_wrap: a parameterised MAX and width, with inc and load inputs, wrapping to 0. Instantiated for the three shadow fields.
- The FSM, blink, repeat and timeout logic stay in the top.

Test Plan:
Simulation parameters: CLK_HZ=100, BLINK_HALF_CYC=5, REPEAT_CYC=8, TIMEOUT_SEC=1.
- Reset, idle: run_en=1, load=0, blink_mask=0, edit_state=0 for 50 cycles.
- cur=12:34:56, mode pulse: edit_state=1, run_en=0, shadow=12:34:56. Three inc pulses -> load_hour=15. Mode x3 -> exactly one load cycle with 15:34:56, edit_state=0.
- SET_M with shadow min=58, two inc pulses -> 59 then 0; load_hour is unchanged (no carry).
- SET_S, inc_pulse then inc_level held 20 cycles -> +1 at the pulse, +1 at 8 cycles, +1 at 16 cycles (3 total). Release -> no further increments.
- SET_H, idle -> blink_mask alternates 6'b110000 and 0 every 5 cycles. At 100 idle cycles: edit_state=0, run_en=1, load never asserted.
- Same-cycle mode_pulse+inc_pulse in SET_H -> state SET_M, hour unchanged. reset pulse in SET_M -> RUN, no load, mask=0.
